// File: rtl/fpu_pkg.sv
// Shared FPU package: IEEE-754 single-precision field widths, canonical
// special-value encodings, operand classification and the divider state enum.
// Imported by the divider top and by the reusable rounding/packing unit.
package fpu_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int BIAS   = 127;
  localparam int SIG_W  = FRAC_W + 1;   // significand including hidden 1

  localparam logic [EXP_W-1:0] EXP_MAX      = '1;
  localparam logic [31:0]      FP32_QNAN    = 32'h7FC0_0000;
  localparam logic [30:0]      FP32_INF_MAG = 31'h7F80_0000;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp32_t;

  typedef enum logic [1:0] {ZERO, NORMAL, INF, NAN} fp_class_e;

  typedef enum logic [1:0] {IDLE, DIVIDE, NORM} div_state_e;

  typedef struct packed {
    logic invalid;
    logic div_by_zero;
    logic overflow;
    logic underflow;
    logic inexact;
  } fp_flags_t;

  // Subnormals (exp == 0) are classed as ZERO: the unit flushes them.
  function automatic fp_class_e fp32_class(input fp32_t x);
    fp_class_e c;
    if (x.exp == '0)             c = ZERO;
    else if (x.exp == EXP_MAX)   c = (x.frac == '0) ? INF : NAN;
    else                         c = NORMAL;
    return c;
  endfunction

endpackage

// File: rtl/fp32_round_ne.sv
// fp32_round_ne: combinational round-to-nearest-even and result packing for a
// normalised significand, with overflow to signed infinity and flush-to-zero
// on underflow. Shared with the add-shift multiplier.
//   sign_i    result sign
//   exp_i     biased exponent before rounding (10-bit signed, may be out of range)
//   sig_i     24-bit significand, bit 23 is the hidden 1
//   guard_i, round_i, sticky_i   bits below the significand
//   result_o  packed fp32 result
//   flags_o   {invalid, div_by_zero, overflow, underflow, inexact}
//             (only present when IEEE_DIV_FLAGS_EN is defined; invalid and
//             div_by_zero are always 0 from this unit)
module fp32_round_ne
  import fpu_pkg::*;
(
  input  logic              sign_i,
  input  logic signed [9:0] exp_i,
  input  logic [SIG_W-1:0]  sig_i,
  input  logic              guard_i,
  input  logic              round_i,
  input  logic              sticky_i,
  output fp32_t             result_o
`ifdef IEEE_DIV_FLAGS_EN
  ,
  output fp_flags_t         flags_o
`endif
);

  logic              round_up;
  logic [SIG_W:0]    sig_rnd;
  logic              carry;
  logic signed [9:0] carry_ext;
  logic signed [9:0] exp_fin;

  always_comb begin
    // Ties go to the even significand (lsb of sig_i breaks the tie).
    round_up  = guard_i & (round_i | sticky_i | sig_i[0]);
    sig_rnd   = {1'b0, sig_i} + {{SIG_W{1'b0}}, round_up};
    carry     = sig_rnd[SIG_W];
    carry_ext = {9'd0, carry};
    exp_fin   = exp_i + carry_ext;

    result_o      = '0;
    result_o.sign = sign_i;
    if (exp_fin >= 10'sd255) begin
      result_o.exp = EXP_MAX;
    end else if (exp_fin > 10'sd0) begin
      result_o.exp  = exp_fin[7:0];
      // On carry the significand is exactly 2^24, so its fraction is all zero.
      result_o.frac = carry ? sig_rnd[SIG_W-1:1] : sig_rnd[SIG_W-2:0];
    end
  end

`ifdef IEEE_DIV_FLAGS_EN
  always_comb begin
    flags_o           = '0;
    flags_o.overflow  = (exp_fin >= 10'sd255);
    flags_o.underflow = (exp_fin <= 10'sd0);
    flags_o.inexact   = guard_i | round_i | sticky_i
                      | flags_o.overflow | flags_o.underflow;
  end
`endif

endmodule

// File: rtl/ieee_shift_subtract_divider.sv
// ieee_shift_subtract_divider: sequential IEEE-754 single-precision divider,
// result = number1 / number2, restoring shift-subtract, one quotient bit per
// clock (QBITS = 27 iterations), then one normalise/round cycle.
// Special operands (and exponents that already decide the result) bypass the
// loop and complete one edge after acceptance.
//   clk, rst_n      clock, asynchronous active-low reset
//   op              start strobe, sampled only in IDLE
//   number1/number2 dividend/divisor, latched on the accepting edge
//   result          quotient, holds the last completed value
//   busy            high from the accepting edge until the done edge
//   done            one-cycle pulse, result valid from this edge
//   state_dbg       current FSM state
//   flags           {invalid, div_by_zero, overflow, underflow, inexact},
//                   present only when IEEE_DIV_FLAGS_EN is defined
// Handshake: op is taken on a rising edge while busy is low; nothing is
// queued, so op while busy is dropped. done marks the single edge on which
// result (and flags) change.
module ieee_shift_subtract_divider
  import fpu_pkg::*;
#(
  parameter int QBITS = 27
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        op,
  input  logic [31:0] number1,
  input  logic [31:0] number2,
  output logic [31:0] result,
  output logic        busy,
  output logic        done,
  output div_state_e  state_dbg
`ifdef IEEE_DIV_FLAGS_EN
  ,
  output logic [4:0]  flags
`endif
);

  localparam int               CNT_W    = $clog2(QBITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(QBITS - 1);
  localparam int               G_IDX    = QBITS - SIG_W - 1;

  // Operand decode
  fp32_t             n1, n2;
  fp_class_e         c1, c2;
  logic              sgn;
  logic signed [9:0] e1s, e2s, ediff;
  logic              sp_hit;
  logic [31:0]       sp_res;

  // State
  div_state_e        state_q, state_d;
  logic              sign_q, sign_d;
  logic signed [9:0] exp_q, exp_d;
  logic [SIG_W-1:0]  m2_q, m2_d;
  logic [SIG_W:0]    rem_q, rem_d;
  logic [QBITS-1:0]  quo_q, quo_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              special_q, special_d;
  logic [31:0]       sp_res_q, sp_res_d;
  logic [31:0]       result_q, result_d;
  logic              done_q, done_d;

  // Iteration and rounding
  logic              rem_ge;
  logic [SIG_W:0]    sub_diff;
  logic signed [9:0] rn_exp;
  logic [SIG_W-1:0]  rn_sig;
  logic              rn_g, rn_r, rn_s;
  fp32_t             rn_res;

`ifdef IEEE_DIV_FLAGS_EN
  fp_flags_t         sp_flags, sp_flags_q, sp_flags_d;
  fp_flags_t         flags_q, flags_d, rn_flags;
`endif

  always_comb begin
    n1    = fp32_t'(number1);
    n2    = fp32_t'(number2);
    c1    = fp32_class(n1);
    c2    = fp32_class(n2);
    sgn   = n1.sign ^ n2.sign;
    e1s   = {2'b00, n1.exp};
    e2s   = {2'b00, n2.exp};
    ediff = e1s - e2s + 10'(BIAS);

    sp_hit = 1'b1;
    sp_res = {sgn, 31'd0};
`ifdef IEEE_DIV_FLAGS_EN
    sp_flags = '0;
`endif
    if (c1 == NAN || c2 == NAN || (c1 == ZERO && c2 == ZERO) || (c1 == INF && c2 == INF)) begin
      sp_res = FP32_QNAN;
`ifdef IEEE_DIV_FLAGS_EN
      sp_flags.invalid = 1'b1;
`endif
    end else if (c1 == INF) begin
      sp_res = {sgn, FP32_INF_MAG};
    end else if (c2 == ZERO) begin
      sp_res = {sgn, FP32_INF_MAG};
`ifdef IEEE_DIV_FLAGS_EN
      sp_flags.div_by_zero = 1'b1;
`endif
    end else if (c2 == INF || c1 == ZERO) begin
      sp_res = {sgn, 31'd0};
    end else if (ediff >= 10'sd256) begin
      // Normalisation can lower the exponent by at most one: still >= 255.
      sp_res = {sgn, FP32_INF_MAG};
`ifdef IEEE_DIV_FLAGS_EN
      sp_flags.overflow = 1'b1;
      sp_flags.inexact  = 1'b1;
`endif
    end else if (ediff < 10'sd0) begin
      // Rounding can raise the exponent by at most one: still <= 0.
      sp_res = {sgn, 31'd0};
`ifdef IEEE_DIV_FLAGS_EN
      sp_flags.underflow = 1'b1;
      sp_flags.inexact   = 1'b1;
`endif
    end else begin
      sp_hit = 1'b0;
    end
  end

  // Normalisation: q[QBITS-1] set means the quotient is already in [1,2).
  always_comb begin
    if (quo_q[QBITS-1]) begin
      rn_sig = quo_q[QBITS-1 -: SIG_W];
      rn_g   = quo_q[G_IDX];
      rn_r   = quo_q[G_IDX-1];
      rn_s   = (|quo_q[G_IDX-2:0]) | (|rem_q);
      rn_exp = exp_q;
    end else begin
      rn_sig = quo_q[QBITS-2 -: SIG_W];
      rn_g   = quo_q[G_IDX-1];
      rn_r   = quo_q[G_IDX-2];
      rn_s   = (G_IDX > 2) ? (|quo_q[G_IDX-2:0] & ~quo_q[G_IDX-2]) | (|rem_q) : (|rem_q);
      rn_exp = exp_q - 10'sd1;
    end
  end

  fp32_round_ne u_round (
    .sign_i   (sign_q),
    .exp_i    (rn_exp),
    .sig_i    (rn_sig),
    .guard_i  (rn_g),
    .round_i  (rn_r),
    .sticky_i (rn_s),
    .result_o (rn_res)
`ifdef IEEE_DIV_FLAGS_EN
    ,
    .flags_o  (rn_flags)
`endif
  );

  always_comb begin
    state_d   = state_q;
    sign_d    = sign_q;
    exp_d     = exp_q;
    m2_d      = m2_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    cnt_d     = cnt_q;
    special_d = special_q;
    sp_res_d  = sp_res_q;
    result_d  = result_q;
    done_d    = 1'b0;
`ifdef IEEE_DIV_FLAGS_EN
    sp_flags_d = sp_flags_q;
    flags_d    = flags_q;
`endif

    // The remainder stays below 2*M2, so after a subtract it is below M2
    // and the shift never loses a set bit.
    rem_ge   = (rem_q >= {1'b0, m2_q});
    sub_diff = rem_ge ? (rem_q - {1'b0, m2_q}) : rem_q;

    case (state_q)
      IDLE: begin
        if (op) begin
          sign_d    = sgn;
          exp_d     = ediff;
          m2_d      = {1'b1, n2.frac};
          rem_d     = {2'b01, n1.frac};
          quo_d     = '0;
          cnt_d     = '0;
          special_d = sp_hit;
          sp_res_d  = sp_res;
`ifdef IEEE_DIV_FLAGS_EN
          sp_flags_d = sp_flags;
`endif
          state_d   = sp_hit ? NORM : DIVIDE;
        end
      end
      DIVIDE: begin
        rem_d = sub_diff << 1;
        quo_d = {quo_q[QBITS-2:0], rem_ge};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) state_d = NORM;
      end
      NORM: begin
        result_d = special_q ? sp_res_q : rn_res;
        done_d   = 1'b1;
`ifdef IEEE_DIV_FLAGS_EN
        flags_d  = special_q ? sp_flags_q : rn_flags;
`endif
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sign_q    <= 1'b0;
      exp_q     <= '0;
      m2_q      <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      cnt_q     <= '0;
      special_q <= 1'b0;
      sp_res_q  <= '0;
      result_q  <= '0;
      done_q    <= 1'b0;
`ifdef IEEE_DIV_FLAGS_EN
      sp_flags_q <= '0;
      flags_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      sign_q    <= sign_d;
      exp_q     <= exp_d;
      m2_q      <= m2_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      cnt_q     <= cnt_d;
      special_q <= special_d;
      sp_res_q  <= sp_res_d;
      result_q  <= result_d;
      done_q    <= done_d;
`ifdef IEEE_DIV_FLAGS_EN
      sp_flags_q <= sp_flags_d;
      flags_q    <= flags_d;
`endif
    end
  end

  assign result    = result_q;
  assign done      = done_q;
  assign busy      = (state_q != IDLE);
  assign state_dbg = state_q;
`ifdef IEEE_DIV_FLAGS_EN
  assign flags     = flags_q;
`endif

endmodule
